handshake_constant_rr_sched: RTL and testbench

- Shares one configurable constant source among NUM_REQ dataflow control requesters, using round-robin arbitration.
- Each accepted control token yields one registered output token carrying the constant plus the index of the winning requester.
- Sits between several control-only producers and a single consumer of the constant, replacing per-requester constant blocks.
- The constant register is runtime-reloadable through a write-enable config port.

---
 rtl/handshake_constant_rr_sched_if.sv | 25 ++
 rtl/handshake_constant_rr_sched.sv | 99 +++++++++
 tb/tb_handshake_constant_rr_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/handshake_constant_rr_sched_if.sv
// Handshake bundle for handshake_constant_rr_sched: requester tokens, output token and constant reload.
interface handshake_constant_rr_sched_if #(
  parameter int DATA_WIDTH = 37,
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2
);
  logic [NUM_REQ-1:0]    ctrl_valid;
  logic [NUM_REQ-1:0]    ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic [IDX_WIDTH-1:0]  outs_tag;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  cfg_we;
  logic [DATA_WIDTH-1:0] cfg_data;

  modport slave (
    input  ctrl_valid, outs_ready, cfg_we, cfg_data,
    output ctrl_ready, outs, outs_tag, outs_valid
  );

  modport master (
    output ctrl_valid, outs_ready, cfg_we, cfg_data,
    input  ctrl_ready, outs, outs_tag, outs_valid
  );
endinterface

// File: rtl/handshake_constant_rr_sched.sv
// Round-robin shared constant source: each accepted control token emits {const, winner index} one cycle later.
// Optional transfer counter enabled by HANDSHAKE_CONSTANT_RR_SCHED_STATS_EN.
module handshake_constant_rr_sched #(
  parameter int                      DATA_WIDTH  = 37,
  parameter int                      NUM_REQ     = 4,
  parameter int                      IDX_WIDTH   = 2,
  parameter logic [DATA_WIDTH-1:0]   CONST_VALUE = 37'b0101110110000101110111101001011110010
) (
  input  logic clk,
  input  logic rst,
`ifdef HANDSHAKE_CONSTANT_RR_SCHED_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_xfers,
`endif
  handshake_constant_rr_sched_if.slave bus
);

  logic [DATA_WIDTH-1:0] const_q;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [IDX_WIDTH-1:0]  tag_p1;
  logic                  vld_p1;
  logic [IDX_WIDTH-1:0]  ptr;
  logic [IDX_WIDTH-1:0]  win;
  logic                  found;
  logic                  can_acc;
  logic                  acc;
  logic [NUM_REQ-1:0]    rdy;
  int                    idx;

  function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] w);
    return (w == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w + IDX_WIDTH'(1);
  endfunction

  assign can_acc = !vld_p1 | bus.outs_ready;

  // Scan from ptr, wrapping at NUM_REQ (which need not be a power of two).
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.ctrl_valid[idx]) begin
        found = 1'b1;
        win   = IDX_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    rdy = '0;
    if (found && can_acc && rst) rdy[win] = 1'b1;
  end

  assign acc            = |(rdy & bus.ctrl_valid);
  assign bus.ctrl_ready = rdy;

  // ---- stage p1: output slot, pointer and constant ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= '0;
      ptr     <= '0;
      const_q <= CONST_VALUE;
    end else begin
      if (bus.cfg_we) const_q <= bus.cfg_data;
      if (acc) begin
        data_p1 <= const_q;
        tag_p1  <= win;
        vld_p1  <= 1'b1;
        ptr     <= next_ptr(win);
      end else if (bus.outs_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.outs       = data_p1;
  assign bus.outs_tag   = tag_p1;
  assign bus.outs_valid = vld_p1;

`ifdef HANDSHAKE_CONSTANT_RR_SCHED_STATS_EN
  logic [15:0] xfer_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               xfer_q <= '0;
    else if (stat_clr)                      xfer_q <= '0;
    else if (vld_p1 && bus.outs_ready)      xfer_q <= sat_inc16(xfer_q);
  end

  assign stat_xfers = xfer_q;
`endif

endmodule

// File: tb/tb_handshake_constant_rr_sched.sv
// Directed bench for handshake_constant_rr_sched: reset, round-robin order, skip/wrap, backpressure, reload race.
module tb_handshake_constant_rr_sched;
  localparam int DW = 37;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam logic [DW-1:0] CONST_V = 37'b0101110110000101110111101001011110010;
  localparam logic [DW-1:0] NEW_V   = 37'h1_2345_6789;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  handshake_constant_rr_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_WIDTH(IW)) bus ();

`ifdef HANDSHAKE_CONSTANT_RR_SCHED_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_xfers;
`endif

  handshake_constant_rr_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_WIDTH(IW), .CONST_VALUE(CONST_V)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef HANDSHAKE_CONSTANT_RR_SCHED_STATS_EN
    .stat_clr   (stat_clr),
    .stat_xfers (stat_xfers),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.ctrl_valid = 4'b1111;
    bus.outs_ready = 1'b1;
    bus.cfg_we     = 1'b1;
    bus.cfg_data   = 37'h1F_FFFF_FFFF;
`ifdef HANDSHAKE_CONSTANT_RR_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif

    // reset with active inputs
    repeat (3) step();
    check("rst_valid", 64'(bus.outs_valid), 64'd0);
    check("rst_ready", 64'(bus.ctrl_ready), 64'd0);
    check("rst_tag",   64'(bus.outs_tag),   64'd0);
    check("rst_outs",  64'(bus.outs),       64'd0);
    bus.cfg_we     = 1'b0;
    bus.ctrl_valid = 4'b0000;
    rst            = 1'b1;
    step();

    // fairness: all requesting
    bus.ctrl_valid = 4'b1111;
    #1;
    check("rr_ready0", 64'(bus.ctrl_ready), 64'b0001);
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_valid", 64'(bus.outs_valid), 64'd1);
      check("rr_tag",   64'(bus.outs_tag),   64'(i % 4));
      check("rr_outs",  64'(bus.outs),       64'(CONST_V));
      check("rr_ready", 64'(bus.ctrl_ready), 64'(4'b0001 << ((i + 1) % 4)));
    end
    bus.ctrl_valid = 4'b0000;
    step();
    check("drain_valid", 64'(bus.outs_valid), 64'd0);
    check("drain_tag",   64'(bus.outs_tag),   64'd3);

    // skip and wrap
    bus.ctrl_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("skip_tag", 64'(bus.outs_tag), (i % 2 == 0) ? 64'd1 : 64'd3);
    end
    bus.ctrl_valid = 4'b0000;
    step();
    bus.ctrl_valid = 4'b1111;
    #1;
    check("wrap_ptr0", 64'(bus.ctrl_ready), 64'b0001);
    bus.ctrl_valid = 4'b0000;
    #1;

    // backpressure
    bus.outs_ready = 1'b0;
    bus.ctrl_valid = 4'b0100;
    #1;
    check("bp_ready_empty", 64'(bus.ctrl_ready), 64'b0100);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus.outs_valid), 64'd1);
      check("bp_tag",   64'(bus.outs_tag),   64'd2);
      check("bp_ready", 64'(bus.ctrl_ready), 64'd0);
      step();
    end
    bus.outs_ready = 1'b1;
    #1;
    check("bp_reaccept_ready", 64'(bus.ctrl_ready), 64'b0100);
    step();
    check("bp_new_valid", 64'(bus.outs_valid), 64'd1);
    check("bp_new_tag",   64'(bus.outs_tag),   64'd2);
    bus.ctrl_valid = 4'b0000;
    step();
    check("bp_drained", 64'(bus.outs_valid), 64'd0);

    // reconfig race: ptr=3, requester 0 wins
    bus.ctrl_valid = 4'b0001;
    bus.cfg_we     = 1'b1;
    bus.cfg_data   = NEW_V;
    #1;
    check("cfg_ready", 64'(bus.ctrl_ready), 64'b0001);
    step();
    bus.cfg_we = 1'b0;
    check("cfg_old_outs", 64'(bus.outs),     64'(CONST_V));
    check("cfg_old_tag",  64'(bus.outs_tag), 64'd0);
    step();
    check("cfg_new_outs", 64'(bus.outs),     64'(NEW_V));
    check("cfg_new_tag",  64'(bus.outs_tag), 64'd0);
    bus.ctrl_valid = 4'b0000;
    step();
    check("cfg_drain_valid", 64'(bus.outs_valid), 64'd0);
    check("cfg_hold_outs",   64'(bus.outs),       64'(NEW_V));

    // reset mid-transfer discards token, reload and pointer
    bus.ctrl_valid = 4'b0001;
    bus.outs_ready = 1'b0;
    step();
    check("mid_valid", 64'(bus.outs_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.outs_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.ctrl_ready), 64'd0);
    bus.ctrl_valid = 4'b0000;
    bus.outs_ready = 1'b1;
    step();
    rst = 1'b1;
    bus.ctrl_valid = 4'b1111;
    step();
    check("post_rst_outs", 64'(bus.outs),     64'(CONST_V));
    check("post_rst_tag",  64'(bus.outs_tag), 64'd0);
    bus.ctrl_valid = 4'b0000;
    step();

`ifdef HANDSHAKE_CONSTANT_RR_SCHED_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("stat_clr0", 64'(stat_xfers), 64'd0);
    bus.ctrl_valid = 4'b0001;
    repeat (10) step();
    bus.ctrl_valid = 4'b0000;
    step();
    check("stat_ten", 64'(stat_xfers), 64'd10);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("stat_clr1", 64'(stat_xfers), 64'd0);
    bus.ctrl_valid = 4'b0001;
    repeat (65540) step();
    bus.ctrl_valid = 4'b0000;
    step();
    check("stat_sat", 64'(stat_xfers), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
